// File: rtl/num_digits.sv
// num_digits: serial double-dabble binary-to-BCD converter, one bit per cycle, four digit outputs.
// Optional build macro LEADING_ZERO_BLANK_EN shows digits above 'length' as 4'hF instead of 0.
`default_nettype none

module num_digits #(
   parameter int W = 14,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] number,
   output logic         busy,
   output logic         done,
   output logic [3:0]   char1,
   output logic [3:0]   char2,
   output logic [3:0]   char3,
   output logic [3:0]   char4,
   output logic [2:0]   length,
   output logic         overflow
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] c_LAST   = CW'(W - 1);
   localparam logic [0:0]    c_S_IDLE = 1'b0;
   localparam logic [0:0]    c_S_CONV = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0]    c_BLANK  = 4'hF;
`else
   localparam logic [3:0]    c_BLANK  = 4'h0;
`endif

   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;
   logic [W-1:0]  r_shift;
   logic [19:0]   r_bcd;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic          r_ovf;
   logic [2:0]    r_len;
   logic [3:0]    r_c1, r_c2, r_c3, r_c4;

   logic          w_accept;
   logic          w_iter;
   logic          w_last;
   logic [19:0]   w_adj;
   logic [19:0]   w_next;
   logic          w_ovf;
   logic [2:0]    w_len;
   logic [3:0]    w_c1, w_c2, w_c3, w_c4;

   assign w_last = (r_cnt == c_LAST);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (start)  w_state_nxt = c_S_CONV;
         c_S_CONV: if (w_last) w_state_nxt = c_S_IDLE;
         default:              w_state_nxt = c_S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy     = (r_state == c_S_CONV);
      w_accept = (r_state == c_S_IDLE) && start;
      w_iter   = (r_state == c_S_CONV);
   end

   for (genvar g = 0; g < 5; g++) begin : g_adj
      assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                          : r_bcd[4*g +: 4];
   end

   assign w_next = {w_adj[18:0], r_shift[W-1]};

   // A carry out of the accumulator can only mean an oversized input, so it also flags overflow.
   always_comb begin
      w_ovf = (w_next[19:16] != 4'd0) || w_adj[19];
      if (w_next[15:12] != 4'd0)     w_len = 3'd4;
      else if (w_next[11:8] != 4'd0) w_len = 3'd3;
      else if (w_next[7:4] != 4'd0)  w_len = 3'd2;
      else                           w_len = 3'd1;
      w_c1 = w_next[3:0];
      w_c2 = (w_len < 3'd2) ? c_BLANK : w_next[7:4];
      w_c3 = (w_len < 3'd3) ? c_BLANK : w_next[11:8];
      w_c4 = (w_len < 3'd4) ? c_BLANK : w_next[15:12];
      if (w_ovf) begin
         w_len = 3'(N);
         w_c1  = 4'd9;
         w_c2  = 4'd9;
         w_c3  = 4'd9;
         w_c4  = 4'd9;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_len   <= 3'd1;
         r_c1    <= 4'd0;
         r_c2    <= c_BLANK;
         r_c3    <= c_BLANK;
         r_c4    <= c_BLANK;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_shift <= number;
            r_bcd   <= '0;
            r_cnt   <= '0;
         end else if (w_iter) begin
            r_shift <= r_shift << 1;
            r_bcd   <= w_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               r_done <= 1'b1;
               r_ovf  <= w_ovf;
               r_len  <= w_len;
               r_c1   <= w_c1;
               r_c2   <= w_c2;
               r_c3   <= w_c3;
               r_c4   <= w_c4;
            end
         end
      end
   end

   assign done     = r_done;
   assign overflow = r_ovf;
   assign length   = r_len;
   assign char1    = r_c1;
   assign char2    = r_c2;
   assign char3    = r_c3;
   assign char4    = r_c4;

endmodule

`default_nettype wire

// File: tb/tb_num_digits.sv
// Directed self-checking bench for num_digits (default W=14, N=4).
`default_nettype none

module tb_num_digits;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0] c_BLK = 4'hF;
`else
   localparam logic [3:0] c_BLK = 4'h0;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] number;
   logic        busy;
   logic        done;
   logic [3:0]  char1, char2, char3, char4;
   logic [2:0]  length;
   logic        overflow;

   int total;
   int bad;
   int cyc;
   int seen;
   logic busy_mid;

   num_digits #(.W(14), .N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .number   (number),
      .busy     (busy),
      .done     (done),
      .char1    (char1),
      .char2    (char2),
      .char3    (char3),
      .char4    (char4),
      .length   (length),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one accepting edge, then count edges until done (999 on timeout).
   task automatic convert(input logic [13:0] val, output int c);
      number = val;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      c = 999;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            c = i;
            break;
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b0; start = 1'b0; number = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_len", length, 1);
      chk("rst_c1", char1, 0);
      chk("rst_c2", char2, c_BLK);
      chk("rst_c4", char4, c_BLK);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // 2048: latency and four-digit result
      convert(14'd2048, cyc);
      chk("2048_lat", cyc, 14);
      chk("2048_busy_in_done", busy, 0);
      chk("2048_c4", char4, 2);
      chk("2048_c3", char3, 0);
      chk("2048_c2", char2, 4);
      chk("2048_c1", char1, 8);
      chk("2048_len", length, 4);
      chk("2048_ovf", overflow, 0);

      // 0 then 16383 back-to-back, second start issued in the done cycle
      convert(14'd0, cyc);
      chk("zero_len", length, 1);
      chk("zero_c1", char1, 0);
      chk("zero_c2", char2, c_BLK);
      convert(14'd16383, cyc);
      chk("max_lat_b2b", cyc, 14);
      chk("max_ovf", overflow, 1);
      chk("max_c1", char1, 9);
      chk("max_c2", char2, 9);
      chk("max_c3", char3, 9);
      chk("max_c4", char4, 9);
      chk("max_len", length, 4);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);

      // 32: leading digits blank or zero depending on build
      convert(14'd32, cyc);
      chk("32_lat", cyc, 14);
      chk("32_c4", char4, c_BLK);
      chk("32_c3", char3, c_BLK);
      chk("32_c2", char2, 3);
      chk("32_c1", char1, 2);
      chk("32_len", length, 2);
      chk("32_ovf", overflow, 0);

      // Changing number while idle must not disturb held outputs
      number = 14'd777;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_c2", char2, 3);
      chk("hold_len", length, 2);

      // 512 with a second start at cycle 5 while busy
      number = 14'd512; start = 1'b1;
      @(posedge clk); #1;
      cyc = 999; seen = 0; busy_mid = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         if (i == 5) begin
            start = 1'b1; number = 14'd64;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (i == 7) busy_mid = busy;
         if (done) begin
            seen++;
            if (seen == 1) cyc = i;
         end
      end
      chk("512_busy_mid", busy_mid, 1);
      chk("512_single_done", seen, 1);
      chk("512_lat", cyc, 14);
      chk("512_c4", char4, c_BLK);
      chk("512_c3", char3, 5);
      chk("512_c2", char2, 1);
      chk("512_c1", char1, 2);
      chk("512_len", length, 3);

      // Reset at cycle 7 of a conversion aborts it
      number = 14'd1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      chk("abort_busy", busy, 0);
      chk("abort_len", length, 1);
      chk("abort_c1", char1, 0);
      chk("abort_c3", char3, c_BLK);
      chk("abort_ovf", overflow, 0);
      @(negedge clk); rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      convert(14'd9999, cyc);
      chk("9999_lat", cyc, 14);
      chk("9999_c1", char1, 9);
      chk("9999_c2", char2, 9);
      chk("9999_c3", char3, 9);
      chk("9999_c4", char4, 9);
      chk("9999_ovf", overflow, 0);
      chk("9999_len", length, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
